aes_inv_key_expansion: RTL and testbench

- Sequential AES-128 inverse key schedule for the decryption datapath.
- Loads the final (round-10) round key and walks the schedule backwards, one round per handshake, emitting round keys 10, 9, ..., 0 in the order the inverse cipher consumes them.
- Reuses the existing AES_sbox (4 instances, SubWord) and AES_Rcon modules.
- Sits between the key register and the inverse-round datapath.

---
 rtl/aes_inv_key_expansion.sv | 176 +++++++++++++++++
 tb/tb_aes_inv_key_expansion.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_expansion.sv
// Sequential AES-128 inverse key schedule: loads the round-10 key and emits round keys 10..0, one per handshake.
// Optional AES_INV_KEY_PRECOMPUTE_EN: key_in is the cipher key and round 10 is derived internally first.

module AES_sbox (
  input  logic [7:0] value,
  output logic [7:0] sub_value
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset is (255 - value) * 8.
  logic [10:0] bit_pos;
  assign bit_pos   = {~value, 3'b000};
  assign sub_value = SBOX[bit_pos +: 8];
endmodule

module AES_Rcon (
  input  logic [3:0]  cnt,
  output logic [31:0] rcon
);
  always_comb begin
    rcon = '0;
    case (cnt)
      4'd1:    rcon[31:24] = 8'h01;
      4'd2:    rcon[31:24] = 8'h02;
      4'd3:    rcon[31:24] = 8'h04;
      4'd4:    rcon[31:24] = 8'h08;
      4'd5:    rcon[31:24] = 8'h10;
      4'd6:    rcon[31:24] = 8'h20;
      4'd7:    rcon[31:24] = 8'h40;
      4'd8:    rcon[31:24] = 8'h80;
      4'd9:    rcon[31:24] = 8'h1b;
      4'd10:   rcon[31:24] = 8'h36;
      default: rcon[31:24] = 8'h00;
    endcase
  end
endmodule

module aes_inv_key_expansion #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*WIDTH-1:0]   key_in,
  output logic                 busy,
  output logic [4*WIDTH-1:0]   rk_out,
  output logic [3:0]           rk_round,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic                 done
);
`ifdef AES_INV_KEY_PRECOMPUTE_EN
  typedef enum logic [1:0] {IDLE, EMIT, DONE, FWD} state_t;
  logic [3:0] fwd_cnt;
`else
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
`endif

  state_t state;

  logic [WIDTH-1:0] w0, w1, w2, w3;
  logic [WIDTH-1:0] p1, p2, p3;
  logic [WIDTH-1:0] sbox_in, sub_word, rcon;
  logic [3:0]       rcon_cnt;
  logic [4*WIDTH-1:0] prev_key;

  assign w0 = rk_out[127:96];
  assign w1 = rk_out[95:64];
  assign w2 = rk_out[63:32];
  assign w3 = rk_out[31:0];

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

`ifdef AES_INV_KEY_PRECOMPUTE_EN
  // Forward and inverse steps share the four S-boxes; only the word fed in differs.
  logic [WIDTH-1:0]   n0, n1, n2, n3;
  logic [4*WIDTH-1:0] next_key;
  assign sbox_in  = (state == FWD) ? {w3[23:0], w3[31:24]} : {p3[23:0], p3[31:24]};
  assign rcon_cnt = (state == FWD) ? fwd_cnt : rk_round;
  assign n0       = w0 ^ sub_word ^ rcon;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};
`else
  assign sbox_in  = {p3[23:0], p3[31:24]};
  assign rcon_cnt = rk_round;
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      AES_sbox u_sbox (
        .value     (sbox_in[8*gi +: 8]),
        .sub_value (sub_word[8*gi +: 8])
      );
    end
  endgenerate

  AES_Rcon u_rcon (
    .cnt  (rcon_cnt),
    .rcon (rcon)
  );

  assign prev_key = {w0 ^ sub_word ^ rcon, p1, p2, p3};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rk_out   <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef AES_INV_KEY_PRECOMPUTE_EN
      fwd_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk_out <= key_in;
            busy   <= 1'b1;
`ifdef AES_INV_KEY_PRECOMPUTE_EN
            fwd_cnt <= 4'd1;
            state   <= FWD;
`else
            rk_round <= 4'd10;
            rk_valid <= 1'b1;
            state    <= EMIT;
`endif
          end
        end
`ifdef AES_INV_KEY_PRECOMPUTE_EN
        FWD: begin
          rk_out <= next_key;
          if (fwd_cnt == 4'd10) begin
            rk_round <= 4'd10;
            rk_valid <= 1'b1;
            state    <= EMIT;
          end else begin
            fwd_cnt <= fwd_cnt + 4'd1;
          end
        end
`endif
        EMIT: begin
          // rk_valid is always high here, so rk_ready alone completes the handshake.
          if (rk_ready) begin
            if (rk_round == 4'd0) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              rk_out   <= prev_key;
              rk_round <= rk_round - 4'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Scoreboard bench for aes_inv_key_expansion using the FIPS-197 A.1 key schedule.
module tb_aes_inv_key_expansion;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  always #5 clk = ~clk;

  aes_inv_key_expansion #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .done     (done)
  );

`ifdef AES_INV_KEY_PRECOMPUTE_EN
  localparam int PRE = 10;
  localparam int LOAD_IDX = 0;
`else
  localparam int PRE = 0;
  localparam int LOAD_IDX = 10;
`endif

  typedef struct packed {
    logic [3:0]   r;
    logic [127:0] k;
  } exp_t;

  logic [127:0] rk_tab [0:10];
  exp_t         sb_q [$];
  int           tests = 0;
  int           fails = 0;
  int           hs_cnt = 0;
  bit           stop = 1'b0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all();
    for (int r = 10; r >= 0; r--) sb_q.push_back({4'(r), rk_tab[r]});
    hs_cnt = 0;
  endtask

  task automatic do_start(input logic [127:0] key);
    start  = 1'b1;
    key_in = key;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < PRE; i++) begin
      check("fwd_busy_no_valid", 136'({busy, rk_valid}), 136'(2'b10));
      tick();
    end
    check("first_valid", 136'({busy, rk_valid, rk_round}), 136'({1'b1, 1'b1, 4'd10}));
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (rk_round != r && n < 30) begin
      tick();
      n++;
    end
    check("reach_round", 136'(rk_round), 136'(r));
  endtask

  task automatic finish_run(input int exp_cycles);
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check("done_seen", 136'(done), 136'(1));
    if (exp_cycles >= 0) check("stream_cycles", 136'(n), 136'(exp_cycles));
    check("handshakes", 136'(hs_cnt), 136'(11));
    check("queue_drained", 136'(sb_q.size()), 136'(0));
  endtask

  task automatic monitor();
    exp_t e;
    while (!stop) begin
      @(negedge clk);
      if (rst_n && rk_valid && rk_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_key: got round %0d key %h, none expected", rk_round, rk_out);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("key_round_%0d", e.r), 136'({rk_round, rk_out}), 136'({e.r, e.k}));
        end
      end
    end
  endtask

  task automatic stimulus();
    // Reset state
    repeat (3) tick();
    check("reset_outputs", 136'({busy, rk_valid, done, rk_round, rk_out}), 136'(0));
    rst_n = 1'b1;
    tick();

    // Nominal stream with rk_ready held high
    rk_ready = 1'b1;
    push_all();
    do_start(rk_tab[LOAD_IDX]);
    finish_run(11);

    // Start during DONE is ignored; the following cycle's start is accepted
    start  = 1'b1;
    key_in = 128'h0f0e0d0c0b0a09080706050403020100;
    tick();
    check("start_in_done_ignored", 136'({busy, rk_valid, done}), 136'(0));
    push_all();
    do_start(rk_tab[LOAD_IDX]);

    // start with another key while busy at round 7
    wait_round(4'd7);
    start  = 1'b1;
    key_in = 128'h00112233445566778899aabbccddeeff;
    tick();
    start  = 1'b0;
    check("start_busy_ignored", 136'({busy, rk_round}), 136'({1'b1, 4'd6}));

    // Backpressure: hold round 5 for 3 cycles
    wait_round(4'd5);
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 136'({rk_valid, rk_round, rk_out}), 136'({1'b1, 4'd5, rk_tab[5]}));
    end
    rk_ready = 1'b1;
    finish_run(-1);
    tick();
    check("done_one_shot", 136'({done, busy}), 136'(0));

    // Reset in the middle of a run
    push_all();
    do_start(rk_tab[LOAD_IDX]);
    wait_round(4'd4);
    rst_n = 1'b0;
    tick();
    check("mid_reset_outputs", 136'({busy, rk_valid, done, rk_round, rk_out}), 136'(0));
    sb_q.delete();
    rst_n = 1'b1;
    tick();
    push_all();
    do_start(rk_tab[LOAD_IDX]);
    finish_run(11);
    tick();
    stop = 1'b1;
    tick();
  endtask

  initial begin
    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fork
      monitor();
      stimulus();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
